// File: rtl/gray_dec_serial_pkg.sv
// Shared types and constants for the serial Gray-to-binary decoder.
// Optional parity output is enabled with GRAY_DEC_PARITY_EN.
package gray_pkg;

   localparam int unsigned GRAY_WIDTH_DEF = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DECODE = 2'd1,
      HOLD   = 2'd2
   } gray_state_e;

   // Width of the bit-index register; never narrower than one bit.
   function automatic int unsigned idx_width(input int unsigned w);
      return (w <= 2) ? 1 : $clog2(w);
   endfunction

endpackage

// File: rtl/gray_dec_serial_if.sv
// Valid/ready request and result bus of the serial Gray decoder.
import gray_pkg::*;

interface gray_dec_serial_if #(
   parameter int unsigned WIDTH = GRAY_WIDTH_DEF
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] gray_in;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] bin_out;
   logic             busy;

   modport master (
      output in_valid, gray_in, out_ready,
      input  in_ready, out_valid, bin_out, busy
   );

   modport slave (
      input  in_valid, gray_in, out_ready,
      output in_ready, out_valid, bin_out, busy
   );
endinterface

// File: rtl/gray_dec_serial_bit.sv
// Single-bit decode slice: one binary bit from its Gray bit and the next-higher binary bit.
module gray_dec_bit (
   input  logic bin_prev,
   input  logic g_i,
   output logic bin_i
);
   assign bin_i = bin_prev ^ g_i;
endmodule

// File: rtl/gray_dec_serial.sv
// Serial Gray-to-binary decoder, one bit per cycle MSB first, valid/ready on both sides.
// Define GRAY_DEC_PARITY_EN to add the out_parity output.
module gray_dec_serial
   import gray_pkg::*;
#(
   parameter int unsigned WIDTH = GRAY_WIDTH_DEF
) (
   input  logic clk,
   input  logic rst,
   gray_dec_serial_if.slave bus
`ifdef GRAY_DEC_PARITY_EN
   ,
   output logic out_parity
`endif
);
   localparam int unsigned IW = idx_width(WIDTH);

   gray_state_e      state_q;
   logic [WIDTH-1:0] g_q;
   logic [WIDTH-1:0] bin_q;
   logic [IW-1:0]    idx_q;
   logic             out_valid_q;
   logic             in_ready_q;
   logic             busy_q;

   logic             prev_bit;
   logic             g_bit;
   logic             res_bit;

   // Index mux feeding the single shared slice; the MSB has no higher bit, so it sees 0.
   always_comb begin
      prev_bit = 1'b0;
      g_bit    = g_q[idx_q];
      if (idx_q != IW'(WIDTH - 1))
         prev_bit = bin_q[idx_q + IW'(1)];
   end

   gray_dec_bit u_bit (
      .bin_prev (prev_bit),
      .g_i      (g_bit),
      .bin_i    (res_bit)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         g_q         <= '0;
         bin_q       <= '0;
         idx_q       <= '0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
         busy_q      <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.in_valid) begin
                  g_q        <= bus.gray_in;
                  bin_q      <= '0;
                  idx_q      <= IW'(WIDTH - 1);
                  state_q    <= DECODE;
                  in_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
               end
            end
            DECODE: begin
               bin_q[idx_q] <= res_bit;
               if (idx_q == '0) begin
                  state_q     <= HOLD;
                  out_valid_q <= 1'b1;
               end else begin
                  idx_q <= idx_q - IW'(1);
               end
            end
            HOLD: begin
               if (bus.out_ready) begin
                  state_q     <= IDLE;
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  busy_q      <= 1'b0;
               end
            end
            default: begin
               state_q     <= IDLE;
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b1;
               busy_q      <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.bin_out   = bin_q;
   assign bus.busy      = busy_q;

`ifdef GRAY_DEC_PARITY_EN
   assign out_parity = ^bin_q;
`endif

endmodule

// File: tb/tb_gray_dec_serial.sv
// Directed self-checking bench for gray_dec_serial (WIDTH=4).
module tb_gray_dec_serial;
   localparam int unsigned W = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   failures = 0;

   gray_dec_serial_if #(.WIDTH(W)) bus ();

`ifdef GRAY_DEC_PARITY_EN
   logic out_parity;
   gray_dec_serial #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus),
      .out_parity (out_parity)
   );
`else
   gray_dec_serial #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );
`endif

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Transfer one word, measure latency, check result, retention and return to IDLE.
   task automatic do_word(input logic [W-1:0] g, input logic [W-1:0] exp_bin, input string tag);
      int cyc = 0;
      while (!bus.in_ready && cyc < 20) begin
         step();
         cyc++;
      end
      chk({tag, "_rdy"}, bus.in_ready, 1'b1);
      bus.in_valid  = 1'b1;
      bus.gray_in   = g;
      bus.out_ready = 1'b1;
      step();
      bus.in_valid = 1'b0;
      bus.gray_in  = ~g;
      chk({tag, "_busy"}, bus.busy, 1'b1);
      cyc = 0;
      while (!bus.out_valid && cyc < 20) begin
         step();
         cyc++;
      end
      chk({tag, "_lat"}, cyc, W);
      chk({tag, "_bin"}, bus.bin_out, exp_bin);
`ifdef GRAY_DEC_PARITY_EN
      chk({tag, "_par"}, out_parity, ^exp_bin);
`endif
      step();
      chk({tag, "_ov0"}, bus.out_valid, 1'b0);
      chk({tag, "_idle"}, bus.in_ready, 1'b1);
      chk({tag, "_keep"}, bus.bin_out, exp_bin);
   endtask

   initial begin
      int cyc;
      int k;
      int accepted;
      logic [W-1:0] kk;
      logic [W-1:0] expq[$];

      bus.in_valid  = 1'b0;
      bus.gray_in   = '0;
      bus.out_ready = 1'b1;
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      chk("rst_in_ready", bus.in_ready, 1'b1);
      chk("rst_out_valid", bus.out_valid, 1'b0);
      chk("rst_bin", bus.bin_out, 4'b0000);
      chk("rst_busy", bus.busy, 1'b0);
`ifdef GRAY_DEC_PARITY_EN
      chk("rst_par", out_parity, 1'b0);
`endif

      do_word(4'b0000, 4'b0000, "g0000");
      do_word(4'b1000, 4'b1111, "g1000");
      do_word(4'b0110, 4'b0100, "g0110");
      do_word(4'b0111, 4'b0101, "g0111");

      // Sweep: gray_in changes every cycle with in_valid held high.
      accepted = 0;
      k = 0;
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      for (int c = 0; c < 100; c++) begin
         if (bus.out_valid) begin
            if (expq.size() == 0) chk("sweep_extra", 1'b1, 1'b0);
            else chk("sweep_bin", bus.bin_out, expq.pop_front());
         end
         chk("sweep_rdy_busy", bus.in_ready, !bus.busy);
         kk = 4'(k);
         bus.gray_in = kk ^ (kk >> 1);
         if (bus.in_ready) begin
            expq.push_back(kk);
            accepted++;
         end
         k = (k + 1) % 16;
         step();
      end
      bus.in_valid = 1'b0;
      cyc = 0;
      while (expq.size() != 0 && cyc < 20) begin
         if (bus.out_valid) chk("sweep_bin", bus.bin_out, expq.pop_front());
         step();
         cyc++;
      end
      chk("sweep_drained", expq.size(), 0);
      chk("sweep_count", accepted, 100 / (W + 2) + ((100 % (W + 2)) != 0 ? 1 : 0));

      // Back-pressure in HOLD.
      cyc = 0;
      while (!bus.in_ready && cyc < 20) begin
         step();
         cyc++;
      end
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.gray_in   = 4'b1000;
      step();
      bus.in_valid = 1'b0;
      cyc = 0;
      while (!bus.out_valid && cyc < 20) begin
         step();
         cyc++;
      end
      chk("bp_lat", cyc, W);
      for (int i = 0; i < 5; i++) begin
         step();
         chk("bp_ov", bus.out_valid, 1'b1);
         chk("bp_bin", bus.bin_out, 4'b1111);
         chk("bp_rdy", bus.in_ready, 1'b0);
      end
      bus.out_ready = 1'b1;
      step();
      chk("bp_release", bus.out_valid, 1'b0);
      chk("bp_idle", bus.in_ready, 1'b1);

      // Reset during DECODE discards the word.
      bus.in_valid = 1'b1;
      bus.gray_in  = 4'b1010;
      step();
      bus.in_valid = 1'b0;
      step();
      step();
      chk("mid_busy", bus.busy, 1'b1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("mid_rst_bin", bus.bin_out, 4'b0000);
      chk("mid_rst_ov", bus.out_valid, 1'b0);
      chk("mid_rst_rdy", bus.in_ready, 1'b1);
      chk("mid_rst_busy", bus.busy, 1'b0);
      do_word(4'b0001, 4'b0001, "g0001");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end
endmodule
